// File: rtl/instr_encoder_pkg.sv
// Shared field widths, MIPS opcode/funct codes and encoder FSM states.
package instr_encoder_pkg;

    localparam int unsigned OPCODE_WIDTH = 6;
    localparam int unsigned FUNCT_WIDTH  = 6;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_RTYPE  = 6'h00,
        OP_BRANCH = 6'h04,
        OP_ADDI   = 6'h08,
        OP_ADDIU  = 6'h09,
        OP_SLTI   = 6'h0A,
        OP_SLTIU  = 6'h0B,
        OP_ANDI   = 6'h0C,
        OP_ORI    = 6'h0D,
        OP_XORI   = 6'h0E,
        OP_LOAD   = 6'h23,
        OP_STORE  = 6'h2B
    } opcode_e;

    typedef enum logic [FUNCT_WIDTH-1:0] {
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_XOR = 6'h26
    } funct_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields -> 32-bit MIPS word plus an illegal flag.
module instr_pack
    import instr_encoder_pkg::*;
#(
    parameter int unsigned AWIDTH    = 5,
    parameter int unsigned IWIDTH    = 32,
    parameter int unsigned IMM_WIDTH = 16
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    input  logic [AWIDTH-1:0]       rs,
    input  logic [AWIDTH-1:0]       rt,
    input  logic [AWIDTH-1:0]       rd,
    input  logic [IMM_WIDTH-1:0]    imm,
    output logic [IWIDTH-1:0]       word,
    output logic                    illegal
);

    // Pick the field layout from the opcode; unknown encodings become a NOP word.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR:
                        word = IWIDTH'({opcode, rs, rt, rd, 5'b0, funct});
                    default:
                        illegal = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE, OP_BRANCH, OP_ADDI, OP_ADDIU,
            OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
                word = IWIDTH'({opcode, rs, rt, imm});
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded field sets over valid/ready and streams
// packed words into instruction memory from a programmable base address.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned AWIDTH     = 5,
    parameter int unsigned IWIDTH     = 32,
    parameter int unsigned IMM_WIDTH  = 16,
    parameter int unsigned MEM_AWIDTH = 8
) (
    input  logic                    e_clk,
    input  logic                    e_rst,
    input  logic                    e_i_start,
    input  logic [MEM_AWIDTH-1:0]   e_i_base,
    input  logic                    e_i_valid,
    output logic                    e_o_ready,
    input  logic                    e_i_last,
    input  logic [OPCODE_WIDTH-1:0] e_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  e_i_funct,
    input  logic [AWIDTH-1:0]       e_i_addr_rs,
    input  logic [AWIDTH-1:0]       e_i_addr_rt,
    input  logic [AWIDTH-1:0]       e_i_addr_rd,
    input  logic [IMM_WIDTH-1:0]    e_i_imm,
    output logic                    e_o_we,
    output logic [MEM_AWIDTH-1:0]   e_o_waddr,
    output logic [IWIDTH-1:0]       e_o_instr,
    output logic [MEM_AWIDTH:0]     e_o_count,
    output logic                    e_o_done,
    output logic                    e_o_err
);

    state_e                state, state_nxt;
    logic [MEM_AWIDTH-1:0] ptr;
    logic [MEM_AWIDTH:0]   count;
    logic                  err;
    logic                  xfer;
    logic                  at_last_slot;
    logic                  count_full;
    logic [IWIDTH-1:0]     pack_word;
    logic                  pack_illegal;

    // count never exceeds DEPTH, so its MSB alone flags "full" and all-ones
    // in the low bits flags the final free slot.
    assign count_full   = count[MEM_AWIDTH];
    assign at_last_slot = !count[MEM_AWIDTH] && (&count[MEM_AWIDTH-1:0]);

    instr_pack #(
        .AWIDTH    (AWIDTH),
        .IWIDTH    (IWIDTH),
        .IMM_WIDTH (IMM_WIDTH)
    ) u_pack (
        .opcode  (e_i_opcode),
        .funct   (e_i_funct),
        .rs      (e_i_addr_rs),
        .rt      (e_i_addr_rt),
        .rd      (e_i_addr_rd),
        .imm     (e_i_imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // State register.
    always_ff @(posedge e_clk) begin
        if (e_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state, ready and transfer decode; start overrides everything.
    always_comb begin
        state_nxt = state;
        e_o_ready = 1'b0;
        xfer      = 1'b0;
        if (e_i_start) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: begin
                    e_o_ready = !count_full;
                    xfer      = e_i_valid && !count_full;
                    if (xfer && (e_i_last || at_last_slot))
                        state_nxt = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    // Write port registers, address pointer, word count and sticky error.
    always_ff @(posedge e_clk) begin
        if (e_rst) begin
            ptr       <= '0;
            count     <= '0;
            err       <= 1'b0;
            e_o_we    <= 1'b0;
            e_o_waddr <= '0;
            e_o_instr <= '0;
        end else begin
            e_o_we <= xfer;
            if (e_i_start) begin
                ptr   <= e_i_base;
                count <= '0;
                err   <= 1'b0;
            end else if (xfer) begin
                e_o_waddr <= ptr;
                e_o_instr <= pack_word;
                ptr       <= ptr + MEM_AWIDTH'(1);
                if (!count_full)
                    count <= count + (MEM_AWIDTH+1)'(1);
                if (pack_illegal || (at_last_slot && !e_i_last))
                    err <= 1'b1;
            end
        end
    end

    assign e_o_count = count;
    assign e_o_err   = err;
    assign e_o_done  = (state == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// loads checked against an arithmetic encoding model.
module tb_instr_encoder;

    logic        clk, rst;
    logic        valid, last;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    // default instance (DEPTH = 256)
    logic        start_a, ready_a, we_a, done_a, err_a;
    logic [7:0]  base_a, waddr_a;
    logic [31:0] instr_a;
    logic [8:0]  count_a;

    // small instance (DEPTH = 4)
    logic        start_b, ready_b, we_b, done_b, err_b;
    logic [1:0]  base_b, waddr_b;
    logic [31:0] instr_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] legal_ops [11] = '{6'h00, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                   6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
    logic [5:0] legal_fns [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

    instr_encoder u_dut_a (
        .e_clk(clk), .e_rst(rst), .e_i_start(start_a), .e_i_base(base_a),
        .e_i_valid(valid), .e_o_ready(ready_a), .e_i_last(last),
        .e_i_opcode(opcode), .e_i_funct(funct), .e_i_addr_rs(rs),
        .e_i_addr_rt(rt), .e_i_addr_rd(rd), .e_i_imm(imm),
        .e_o_we(we_a), .e_o_waddr(waddr_a), .e_o_instr(instr_a),
        .e_o_count(count_a), .e_o_done(done_a), .e_o_err(err_a)
    );

    instr_encoder #(.MEM_AWIDTH(2)) u_dut_b (
        .e_clk(clk), .e_rst(rst), .e_i_start(start_b), .e_i_base(base_b),
        .e_i_valid(valid), .e_o_ready(ready_b), .e_i_last(last),
        .e_i_opcode(opcode), .e_i_funct(funct), .e_i_addr_rs(rs),
        .e_i_addr_rt(rt), .e_i_addr_rd(rd), .e_i_imm(imm),
        .e_o_we(we_b), .e_o_waddr(waddr_b), .e_o_instr(instr_b),
        .e_o_count(count_b), .e_o_done(done_b), .e_o_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoding from the MIPS field positions: returns {illegal, word}.
    function automatic logic [32:0] ref_encode(input logic [5:0] op, input logic [5:0] fn,
                                               input logic [4:0] s, input logic [4:0] t,
                                               input logic [4:0] d, input logic [15:0] im);
        logic [31:0] w;
        logic        bad;
        w   = 32'd0;
        bad = 1'b1;
        if (op == 6'd0) begin
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26}) begin
                w   = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(fn);
                bad = 1'b0;
            end
        end else if (op inside {6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                6'h0D, 6'h0E, 6'h23, 6'h2B}) begin
            w   = (32'(op) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
            bad = 1'b0;
        end
        return {bad, w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] d, input logic [15:0] im);
        opcode = op; funct = fn; rs = s; rt = t; rd = d; imm = im;
    endtask

    task automatic rand_fields(input bit allow_bad);
        opcode = legal_ops[$urandom_range(10)];
        funct  = legal_fns[$urandom_range(4)];
        if (allow_bad && $urandom_range(7) == 0) opcode = 6'($urandom_range(63));
        if (allow_bad && $urandom_range(7) == 0) funct  = 6'($urandom_range(63));
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({we_a, waddr_a, instr_a, count_a, done_a, err_a, ready_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: we=%b waddr=%h instr=%h count=%0d done=%b err=%b ready=%b, required all zero",
                     we_a, waddr_a, instr_a, count_a, done_a, err_a, ready_a);
        end
        n_checks++;
        if ({we_b, waddr_b, instr_b, count_b, done_b, err_b, ready_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: we=%b waddr=%h instr=%h count=%0d done=%b err=%b ready=%b, required all zero",
                     we_b, waddr_b, instr_b, count_b, done_b, err_b, ready_b);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_add();
        start_a = 1'b1; base_a = 8'h10;
        step();
        start_a = 1'b0;
        set_fields(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);
        valid = 1'b1; last = 1'b1;
        #1;
        n_checks++;
        if (ready_a !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", ready_a); end
        step();
        valid = 1'b0; last = 1'b0;
        n_checks++;
        if (we_a !== 1'b1 || waddr_a !== 8'h10 || instr_a !== 32'h00221820) begin
            n_fail++;
            $display("FAIL single_write: we=%b waddr=%h instr=%h, required 1 10 00221820", we_a, waddr_a, instr_a);
        end
        step();
        n_checks++;
        if (done_a !== 1'b1 || count_a !== 9'd1 || err_a !== 1'b0 || we_a !== 1'b0 || ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%b count=%0d err=%b we=%b ready=%b, required 1 1 0 0 0",
                     done_a, count_a, err_a, we_a, ready_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3] = '{32'h8C850008, 32'h2006FFFF, 32'h34C700F0};
        start_a = 1'b1; base_a = 8'h40;
        step();
        start_a = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_fields(6'h23, 6'h00, 5'd4, 5'd5, 5'd0, 16'h0008);
                1: set_fields(6'h08, 6'h00, 5'd0, 5'd6, 5'd0, 16'hFFFF);
                default: set_fields(6'h0D, 6'h00, 5'd6, 5'd7, 5'd0, 16'h00F0);
            endcase
            last = (i == 2);
            step();
            n_checks++;
            if (we_a !== 1'b1 || waddr_a !== 8'(8'h40 + i) || instr_a !== exp_w[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: we=%b waddr=%h instr=%h, required 1 %h %h",
                         i, we_a, waddr_a, instr_a, 8'(8'h40 + i), exp_w[i]);
            end
        end
        valid = 1'b0; last = 1'b0;
        step();
        n_checks++;
        if (count_a !== 9'd3 || done_a !== 1'b1 || err_a !== 1'b0 || we_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: count=%0d done=%b err=%b we=%b, required 3 1 0 0", count_a, done_a, err_a, we_a);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] exp_w [3] = '{32'h0, 32'h0, 32'h00221820};
        logic [7:0]  exp_a [3] = '{8'hFF, 8'h00, 8'h01};
        start_a = 1'b1; base_a = 8'hFF;
        step();
        start_a = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_fields(6'h3F, 6'h20, 5'd9, 5'd10, 5'd11, 16'h1234);
                1: set_fields(6'h00, 6'h07, 5'd1, 5'd2, 5'd3, 16'h0);
                default: set_fields(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);
            endcase
            last = (i == 2);
            step();
            n_checks++;
            if (we_a !== 1'b1 || waddr_a !== exp_a[i] || instr_a !== exp_w[i] || err_a !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal_word%0d: we=%b waddr=%h instr=%h err=%b, required 1 %h %h 1",
                         i, we_a, waddr_a, instr_a, err_a, exp_a[i], exp_w[i]);
            end
        end
        valid = 1'b0; last = 1'b0;
        step();
        n_checks++;
        if (err_a !== 1'b1 || count_a !== 9'd3 || done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_sticky: err=%b count=%0d done=%b, required 1 3 1", err_a, count_a, done_a);
        end
        start_a = 1'b1; base_a = 8'h00;
        step();
        start_a = 1'b0;
        n_checks++;
        if (err_a !== 1'b0 || done_a !== 1'b0 || count_a !== 9'd0) begin
            n_fail++;
            $display("FAIL illegal_clear: err=%b done=%b count=%0d, required 0 0 0", err_a, done_a, count_a);
        end
    endtask

    task automatic test_start_collision();
        start_a = 1'b1; base_a = 8'h20;
        step();
        start_a = 1'b0;
        set_fields(6'h00, 6'h22, 5'd7, 5'd8, 5'd9, 16'h0);
        valid = 1'b1; last = 1'b0;
        step();
        n_checks++;
        if (we_a !== 1'b1 || waddr_a !== 8'h20) begin
            n_fail++;
            $display("FAIL collide_pre: we=%b waddr=%h, required 1 20", we_a, waddr_a);
        end
        start_a = 1'b1; base_a = 8'h80;
        #1;
        n_checks++;
        if (ready_a !== 1'b0) begin n_fail++; $display("FAIL collide_ready: got %b required 0", ready_a); end
        step();
        start_a = 1'b0;
        n_checks++;
        if (we_a !== 1'b0 || count_a !== 9'd0) begin
            n_fail++;
            $display("FAIL collide_nowrite: we=%b count=%0d, required 0 0", we_a, count_a);
        end
        last = 1'b1;
        step();
        valid = 1'b0; last = 1'b0;
        n_checks++;
        if (we_a !== 1'b1 || waddr_a !== 8'h80 || count_a !== 9'd1 || instr_a !== 32'h00E84822) begin
            n_fail++;
            $display("FAIL collide_newbase: we=%b waddr=%h count=%0d instr=%h, required 1 80 1 00e84822",
                     we_a, waddr_a, count_a, instr_a);
        end
    endtask

    task automatic test_wrap_small();
        logic [32:0] enc;
        int          n_xfer;
        start_b = 1'b1; base_b = 2'd3;
        step();
        start_b = 1'b0;
        valid = 1'b1; last = 1'b0;
        n_xfer = 0;
        for (int cyc = 0; cyc < 8 && n_xfer < 4; cyc++) begin
            rand_fields(0);
            enc = ref_encode(opcode, funct, rs, rt, rd, imm);
            #1;
            if (ready_b === 1'b1) begin
                step();
                n_checks++;
                if (we_b !== 1'b1 || waddr_b !== 2'(3 + n_xfer) || instr_b !== enc[31:0]) begin
                    n_fail++;
                    $display("FAIL wrap_word%0d: we=%b waddr=%0d instr=%h, required 1 %0d %h",
                             n_xfer, we_b, waddr_b, instr_b, 2'(3 + n_xfer), enc[31:0]);
                end
                n_xfer++;
            end else begin
                step();
            end
        end
        n_checks++;
        if (n_xfer != 4) begin n_fail++; $display("FAIL wrap_xfers: got %0d transfers required 4", n_xfer); end
        n_checks++;
        if (ready_b !== 1'b0 || done_b !== 1'b1 || err_b !== 1'b1 || count_b !== 3'd4) begin
            n_fail++;
            $display("FAIL wrap_full: ready=%b done=%b err=%b count=%0d, required 0 1 1 4",
                     ready_b, done_b, err_b, count_b);
        end
        step();
        valid = 1'b0;
        n_checks++;
        if (we_b !== 1'b0 || count_b !== 3'd4) begin
            n_fail++;
            $display("FAIL wrap_hold: we=%b count=%0d, required 0 4", we_b, count_b);
        end
    endtask

    task automatic test_random();
        for (int ld = 0; ld < 6; ld++) begin
            logic [7:0]  base, exp_waddr;
            logic [31:0] exp_word;
            logic [32:0] enc;
            logic        exp_err, exp_we;
            int          nwords, sent, guard;
            base   = 8'($urandom);
            nwords = $urandom_range(20, 1);
            start_a = 1'b1; base_a = base; valid = 1'b0;
            step();
            start_a = 1'b0;
            sent = 0; guard = 0; exp_err = 1'b0;
            exp_word = '0; exp_waddr = '0;
            while (sent < nwords && guard < 200) begin
                guard++;
                valid = ($urandom_range(3) != 0);
                rand_fields(1);
                last = (sent == nwords - 1);
                #1;
                n_checks++;
                if (ready_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_ready: load %0d word %0d got %b required 1", ld, sent, ready_a);
                end
                exp_we = valid;
                if (valid) begin
                    enc       = ref_encode(opcode, funct, rs, rt, rd, imm);
                    exp_word  = enc[31:0];
                    exp_waddr = base + 8'(sent);
                    exp_err   = exp_err | enc[32];
                    sent++;
                end
                step();
                n_checks++;
                if (we_a !== exp_we || (exp_we && (waddr_a !== exp_waddr || instr_a !== exp_word))) begin
                    n_fail++;
                    $display("FAIL rand_write: load %0d we=%b waddr=%h instr=%h, required %b %h %h",
                             ld, we_a, waddr_a, instr_a, exp_we, exp_waddr, exp_word);
                end
            end
            valid = 1'b0; last = 1'b0;
            n_checks++;
            if (sent != nwords) begin
                n_fail++;
                $display("FAIL rand_timeout: load %0d sent %0d required %0d", ld, sent, nwords);
            end
            step();
            n_checks++;
            if (count_a !== 9'(nwords) || err_a !== exp_err || done_a !== 1'b1 || we_a !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_end: load %0d count=%0d err=%b done=%b we=%b, required %0d %b 1 0",
                         ld, count_a, err_a, done_a, we_a, nwords, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_a = 1'b1; base_a = 8'h33;
        step();
        start_a = 1'b0;
        set_fields(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);
        valid = 1'b1; last = 1'b0;
        step();
        n_checks++;
        if (we_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: we=%b required 1", we_a); end
        rst = 1'b1; valid = 1'b0;
        step();
        n_checks++;
        if ({we_a, waddr_a, instr_a, count_a, done_a, err_a, ready_a} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_after: we=%b waddr=%h instr=%h count=%0d done=%b err=%b ready=%b, required all zero",
                     we_a, waddr_a, instr_a, count_a, done_a, err_a, ready_a);
        end
        rst = 1'b0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (we_a !== 1'b0 || count_a !== 9'd0 || instr_a !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_drop: we=%b count=%0d instr=%h, required 0 0 0", we_a, count_a, instr_a);
        end
        #1;
        n_checks++;
        if (ready_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_ready: got %b required 0", ready_a); end
        step();
        valid = 1'b0;
        n_checks++;
        if (we_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: we=%b done=%b, required 0 0", we_a, done_a);
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; last = 1'b0;
        start_a = 1'b0; base_a = '0;
        start_b = 1'b0; base_b = '0;
        set_fields('0, '0, '0, '0, '0, '0);
        test_reset();
        test_single_add();
        test_back_to_back();
        test_illegal();
        test_start_collision();
        test_wrap_small();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
